// File: rtl/vga_timing_gen.sv
// VGA 640x480@60 timing generator in the pixel-clock domain, gated by a synchronised PLL lock.
// Latency: outputs lag the h/v counters by 1 clk (sync/de/strobes by 1+SYNC_DELAY with VGA_SYNC_DELAY_EN).
// Backpressure: none, free-running raster; the counters hold at (0,0) while lock is absent.
module vga_timing_gen #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   X_W        = 10,
    parameter int   Y_W        = 10,
    parameter int   SYNC_DELAY = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           locked,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic [X_W-1:0] pixel_x,
    output logic [Y_W-1:0] pixel_y,
    output logic           line_start,
    output logic           frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);

    localparam logic [HC_W-1:0] H_LAST     = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] H_VIS_END  = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0] H_SYNC_BEG = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0] H_SYNC_END = HC_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VC_W-1:0] V_LAST     = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] V_VIS_END  = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0] V_SYNC_BEG = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0] V_SYNC_END = VC_W'(V_ACTIVE + V_FP + V_SYNC);

    // Bundle order: {hsync, vsync, de, line_start, frame_start}
    localparam logic [4:0] SYNC_RST = {~SYNC_POL, ~SYNC_POL, 3'b000};

    logic            lk1;
    logic            lk2;
    logic            run;
    logic [HC_W-1:0] h_cnt;
    logic [VC_W-1:0] v_cnt;

    // locked is asynchronous to clk, so it passes through two flops before use
    always_ff @(posedge clk) begin
        if (rst) begin
            lk1 <= 1'b0;
            lk2 <= 1'b0;
        end else begin
            lk1 <= locked;
            lk2 <= lk1;
        end
    end

    assign run = lk2 & ~rst;

    always_ff @(posedge clk) begin
        if (!run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    logic           h_vis;
    logic           v_vis;
    logic           h_sync_on;
    logic           v_sync_on;
    logic           de_d;
    logic [4:0]     sync_d;
    logic [X_W-1:0] x_d;
    logic [Y_W-1:0] y_d;

    always_comb begin
        h_vis     = (h_cnt < H_VIS_END);
        v_vis     = (v_cnt < V_VIS_END);
        h_sync_on = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
        v_sync_on = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
        de_d      = run & h_vis & v_vis;
        sync_d    = {(run & h_sync_on) ? SYNC_POL : ~SYNC_POL,
                     (run & v_sync_on) ? SYNC_POL : ~SYNC_POL,
                     de_d,
                     run & (h_cnt == '0),
                     run & (h_cnt == '0) & (v_cnt == '0)};
        x_d       = de_d ? X_W'(h_cnt) : '0;
        y_d       = de_d ? Y_W'(v_cnt) : '0;
    end

    logic [4:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= SYNC_RST;
            pixel_x <= '0;
            pixel_y <= '0;
        end else begin
            sync_q  <= sync_d;
            pixel_x <= x_d;
            pixel_y <= y_d;
        end
    end

    logic [4:0] sync_out;

`ifdef VGA_SYNC_DELAY_EN
    // Extra stages line the sync bundle up with framebuffer data fetched at pixel_x/pixel_y
    logic [4:0] dly_q [SYNC_DELAY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_DELAY; i++) begin
                dly_q[i] <= SYNC_RST;
            end
        end else begin
            dly_q[0] <= sync_q;
            for (int i = 1; i < SYNC_DELAY; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign sync_out = dly_q[SYNC_DELAY-1];
`else
    assign sync_out = sync_q;
`endif

    assign hsync       = sync_out[4];
    assign vsync       = sync_out[3];
    assign de          = sync_out[2];
    assign line_start  = sync_out[1];
    assign frame_start = sync_out[0];

endmodule
